// File: rtl/bus_xbar_pkg.sv
// Shared types and helpers for the round-robin bus crossbar: index widths,
// the in-order tracker entry, and the data returned with local error responses.
package bus_xbar_pkg;

  localparam int MaxHostIdxW = 3;  // up to 8 hosts
  localparam int MaxDevIdxW  = 4;  // up to 16 devices

  // Local error responses (decode miss, timeout) return all-zero read data.
  localparam logic [255:0] ErrRdata = '0;

  function automatic int HostIdxW(input int nr_hosts);
    return (nr_hosts <= 1) ? 1 : $clog2(nr_hosts);
  endfunction

  function automatic int DevIdxW(input int nr_devices);
    return (nr_devices <= 1) ? 1 : $clog2(nr_devices);
  endfunction

  typedef struct packed {
    logic [MaxHostIdxW-1:0] host_idx;
    logic [MaxDevIdxW-1:0]  dev_idx;
    logic                   miss;
  } trk_entry_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, searching upward from the host
// after the last winner. The last-grant pointer moves only on an enabled grant.
module bus_rr_arbiter
  import bus_xbar_pkg::*;
#(
  parameter int NrHosts = 2,
  localparam int IdxW   = HostIdxW(NrHosts)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NrHosts-1:0] i_req,
  input  logic               i_en,
  output logic [NrHosts-1:0] o_gnt,
  output logic [IdxW-1:0]    o_gnt_idx,
  output logic               o_gnt_valid
);

  logic [IdxW-1:0]    r_last_grant;
  logic [NrHosts-1:0] w_req_hi;
  logic [NrHosts-1:0] w_pick;

  // Requests above the last winner take precedence; otherwise wrap to the lowest.
  always_comb begin
    w_req_hi = '0;
    for (int h = 0; h < NrHosts; h++) begin
      w_req_hi[h] = i_req[h] && (IdxW'(h) > r_last_grant);
    end
    w_pick      = (|w_req_hi) ? w_req_hi : i_req;
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_valid = |i_req;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (w_pick[h]) begin
        o_gnt     = '0;
        o_gnt[h]  = 1'b1;
        o_gnt_idx = IdxW'(h);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= IdxW'(NrHosts - 1);
    end else if (i_en && o_gnt_valid) begin
      r_last_grant <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/bus_rr_xbar.sv
// N-host / M-device address-decoded bus with round-robin arbitration, an
// in-order outstanding-transaction tracker, local decode-miss errors and a response watchdog.
module bus_rr_xbar
  import bus_xbar_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int NrDevices      = 8,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2,
  parameter int TimeoutCycles  = 1024
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic [NrHosts-1:0]                        host_req_i,
  output logic [NrHosts-1:0]                        host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0]                        host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
  output logic [NrHosts-1:0]                        host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
  output logic [NrHosts-1:0]                        host_err_o,
  output logic [NrDevices-1:0]                      device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]    device_addr_o,
  output logic [NrDevices-1:0]                      device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]     device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]       device_wdata_o,
  input  logic [NrDevices-1:0]                      device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]       device_rdata_i,
  input  logic [NrDevices-1:0]                      device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_base_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_mask_i,
  output logic                                      fault_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]       outstanding_o
);

  localparam int HostW = HostIdxW(NrHosts);
  localparam int DevW  = DevIdxW(NrDevices);
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam int PtrW  = (MaxOutstanding <= 1) ? 1 : $clog2(MaxOutstanding);
  localparam int TmrW  = $clog2(TimeoutCycles + 1);
  localparam int BeW   = DataWidth / 8;

  // Handshake: a request is accepted in the cycle host_gnt_o is high (no
  // ready/valid backpressure beyond that); responses are single-cycle pulses of
  // host_rvalid_o with rdata/err valid only in that cycle, delivered in grant order.

  trk_entry_t             r_fifo [MaxOutstanding];
  logic [PtrW-1:0]        r_wptr;
  logic [PtrW-1:0]        r_rptr;
  logic [CntW-1:0]        r_count;
  logic [TmrW-1:0]        r_timer;
  logic                   r_fault;

  logic                   w_can_grant;
  logic [NrHosts-1:0]     w_arb_req;
  logic [NrHosts-1:0]     w_gnt;
  logic [HostW-1:0]       w_gnt_idx;
  logic                   w_gnt_valid;
  logic [AddressWidth-1:0] w_sel_addr;
  logic                   w_sel_we;
  logic [BeW-1:0]         w_sel_be;
  logic [DataWidth-1:0]   w_sel_wdata;
  logic                   w_hit;
  logic [DevW-1:0]        w_dev_idx;
  trk_entry_t             w_push_entry;
  trk_entry_t             w_head;
  logic                   w_empty;
  logic                   w_dev_rvalid;
  logic [DataWidth-1:0]   w_dev_rdata;
  logic                   w_dev_err;
  logic                   w_timeout;
  logic                   w_local_err;
  logic                   w_pop;
  logic [DataWidth-1:0]   w_resp_rdata;
  logic                   w_resp_err;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A full tracker blocks grants even if the head pops in the same cycle.
  assign w_can_grant = !RST && !r_fault && (r_count < CntW'(MaxOutstanding));
  assign w_arb_req   = host_req_i & {NrHosts{w_can_grant}};

  bus_rr_arbiter #(.NrHosts(NrHosts)) u_arbiter (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_req      (w_arb_req),
    .i_en       (1'b1),
    .o_gnt      (w_gnt),
    .o_gnt_idx  (w_gnt_idx),
    .o_gnt_valid(w_gnt_valid)
  );

  assign host_gnt_o = w_gnt;

  always_comb begin
    w_sel_addr  = '0;
    w_sel_we    = 1'b0;
    w_sel_be    = '0;
    w_sel_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_gnt[h]) begin
        w_sel_addr  = host_addr_i[h];
        w_sel_we    = host_we_i[h];
        w_sel_be    = host_be_i[h];
        w_sel_wdata = host_wdata_i[h];
      end
    end
  end

  // Descending scan so the lowest matching device index wins overlapping windows.
  always_comb begin
    w_hit     = 1'b0;
    w_dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((w_sel_addr & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d]) begin
        w_hit     = 1'b1;
        w_dev_idx = DevW'(d);
      end
    end
  end

  always_comb begin
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (w_gnt_valid && w_hit && (w_dev_idx == DevW'(d))) begin
        device_req_o[d]   = 1'b1;
        device_addr_o[d]  = w_sel_addr;
        device_we_o[d]    = w_sel_we;
        device_be_o[d]    = w_sel_be;
        device_wdata_o[d] = w_sel_wdata;
      end
    end
  end

  always_comb begin
    w_push_entry          = '0;
    w_push_entry.host_idx = MaxHostIdxW'(w_gnt_idx);
    w_push_entry.dev_idx  = MaxDevIdxW'(w_dev_idx);
    w_push_entry.miss     = !w_hit;
  end

  assign w_head  = r_fifo[r_rptr];
  assign w_empty = (r_count == '0);

  // Only the head's device is listened to; other rvalids are dropped.
  always_comb begin
    w_dev_rvalid = 1'b0;
    w_dev_rdata  = '0;
    w_dev_err    = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (w_head.dev_idx == MaxDevIdxW'(d)) begin
        w_dev_rvalid = device_rvalid_i[d];
        w_dev_rdata  = device_rdata_i[d];
        w_dev_err    = device_err_i[d];
      end
    end
  end

  assign w_timeout = !RST && !w_empty && !w_head.miss && !w_dev_rvalid &&
                     (r_timer == TmrW'(TimeoutCycles - 1));
  assign w_local_err  = w_head.miss || w_timeout;
  assign w_pop        = !RST && !w_empty && (w_head.miss || w_dev_rvalid || w_timeout);
  assign w_resp_rdata = w_local_err ? ErrRdata[DataWidth-1:0] : w_dev_rdata;
  assign w_resp_err   = w_local_err ? 1'b1 : w_dev_err;

  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_pop && (w_head.host_idx == MaxHostIdxW'(h))) begin
        host_rvalid_o[h] = 1'b1;
        host_rdata_o[h]  = w_resp_rdata;
        host_err_o[h]    = w_resp_err;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_fault <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_gnt_valid) begin
        r_fifo[r_wptr] <= w_push_entry;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_count <= r_count + CntW'(w_gnt_valid) - CntW'(w_pop);
      if (w_pop || w_empty) begin
        r_timer <= '0;
      end else if (!w_head.miss) begin
        r_timer <= r_timer + TmrW'(1);
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign fault_o       = r_fault;
  assign outstanding_o = r_count;

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Directed bench for bus_rr_xbar: a cycle-by-cycle vector table for arbitration,
// decode, ordering and backpressure, plus hand sequences for timeout and reset flush.
module tb_bus_rr_xbar;

  logic              clk;
  logic              rst;
  logic [1:0]        host_req_i;
  logic [1:0]        host_gnt_o;
  logic [1:0][31:0]  host_addr_i;
  logic [1:0]        host_we_i;
  logic [1:0][3:0]   host_be_i;
  logic [1:0][31:0]  host_wdata_i;
  logic [1:0]        host_rvalid_o;
  logic [1:0][31:0]  host_rdata_o;
  logic [1:0]        host_err_o;
  logic [1:0]        device_req_o;
  logic [1:0][31:0]  device_addr_o;
  logic [1:0]        device_we_o;
  logic [1:0][3:0]   device_be_o;
  logic [1:0][31:0]  device_wdata_o;
  logic [1:0]        device_rvalid_i;
  logic [1:0][31:0]  device_rdata_i;
  logic [1:0]        device_err_i;
  logic [1:0][31:0]  cfg_base;
  logic [1:0][31:0]  cfg_mask;
  logic              fault_o;
  logic [1:0]        outstanding_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  bus_rr_xbar #(
    .NrHosts(2), .NrDevices(2), .DataWidth(32), .AddressWidth(32),
    .MaxOutstanding(2), .TimeoutCycles(16)
  ) dut (
    .CLK(clk), .RST(rst),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i),
    .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask),
    .fault_o(fault_o), .outstanding_o(outstanding_o)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic [1:0]  drv;
    logic [31:0] rd0, rd1;
    logic [1:0]  derr;
    logic [1:0]  gnt, dreq, hrv, herr;
    logic [31:0] hrd0, hrd1;
    logic [1:0]  outst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] req, logic [31:0] a0, logic [31:0] a1,
                              logic [1:0] drv, logic [31:0] rd0, logic [31:0] rd1,
                              logic [1:0] derr, logic [1:0] gnt, logic [1:0] dreq,
                              logic [1:0] hrv, logic [1:0] herr, logic [31:0] hrd0,
                              logic [31:0] hrd1, logic [1:0] outst);
    vec_t v;
    v.rst = r; v.req = req; v.a0 = a0; v.a1 = a1; v.drv = drv; v.rd0 = rd0; v.rd1 = rd1;
    v.derr = derr; v.gnt = gnt; v.dreq = dreq; v.hrv = hrv; v.herr = herr;
    v.hrd0 = hrd0; v.hrd1 = hrd1; v.outst = outst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs after the falling edge, settle before sampling.
  task automatic set_in(input logic r, input logic [1:0] req, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [1:0] drv, input logic [31:0] rd0,
                        input logic [31:0] rd1, input logic [1:0] derr);
    @(negedge clk);
    rst             = r;
    host_req_i      = req;
    host_addr_i[0]  = a0;
    host_addr_i[1]  = a1;
    device_rvalid_i = drv;
    device_rdata_i[0] = rd0;
    device_rdata_i[1] = rd1;
    device_err_i    = derr;
    #2;
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  localparam logic [31:0] RAM = 32'h0010_0000;
  localparam logic [31:0] DV1 = 32'h0020_0000;
  localparam logic [31:0] BAD = 32'h4000_0000;

  initial begin
    int resp_cycle;
    rst = 1'b1; host_req_i = '0; host_addr_i = '0; device_rvalid_i = '0;
    device_rdata_i = '0; device_err_i = '0;
    host_we_i       = 2'b10;
    host_be_i[0]    = 4'hF;
    host_be_i[1]    = 4'h3;
    host_wdata_i[0] = 32'h0A0A_0A0A;
    host_wdata_i[1] = 32'h1B1B_1B1B;
    cfg_base[0] = RAM; cfg_mask[0] = 32'hFFFF_0000;
    cfg_base[1] = DV1; cfg_mask[1] = 32'hFFFF_0000;

    //           rst req a0          a1          drv rd0           rd1           derr gnt dreq hrv herr hrd0          hrd1          outst
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'b01, RAM+32'h10, 0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'b00, RAM+32'h10, 0, 2'b01, 32'hCAFEF00D, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'hCAFEF00D, 0, 2'd1));
    vecs.push_back(mk(1, 2'b11, RAM, DV1+4, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'b11, RAM, DV1+4, 2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'b11, RAM, DV1+4, 2'b01, 32'h11110000, 0, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 32'h11110000, 0, 2'd1));
    vecs.push_back(mk(0, 2'b11, RAM, DV1+4, 2'b10, 0, 32'h22220001, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 0, 32'h22220001, 2'd1));
    vecs.push_back(mk(0, 2'b11, RAM, DV1+4, 2'b01, 32'h33330002, 0, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 32'h33330002, 0, 2'd1));
    vecs.push_back(mk(0, 2'b00, RAM, DV1+4, 2'b11, 32'hDEAD0000, 32'h44440003, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 32'h44440003, 2'd1));
    vecs.push_back(mk(0, 2'b01, BAD, 0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'b00, BAD, 0, 2'b01, 32'h12345678, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 2'd1));
    vecs.push_back(mk(0, 2'b10, 0, DV1+8, 2'b00, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'b01, BAD, DV1+8, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'd1));
    vecs.push_back(mk(0, 2'b00, BAD, DV1+8, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'd2));
    vecs.push_back(mk(0, 2'b00, BAD, DV1+8, 2'b10, 0, 32'h55550004, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 32'h55550004, 2'd2));
    vecs.push_back(mk(0, 2'b00, BAD, DV1+8, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 2'd1));
    vecs.push_back(mk(0, 2'b01, RAM+32'h20, 0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'd0));
    vecs.push_back(mk(0, 2'b01, RAM+32'h20, 0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'd1));
    vecs.push_back(mk(0, 2'b01, RAM+32'h20, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'd2));
    vecs.push_back(mk(0, 2'b01, RAM+32'h20, 0, 2'b01, 32'h66660005, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'h66660005, 0, 2'd2));
    vecs.push_back(mk(0, 2'b01, RAM+32'h20, 0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'd1));
    vecs.push_back(mk(0, 2'b00, RAM+32'h20, 0, 2'b01, 32'h77770006, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'h77770006, 0, 2'd2));
    vecs.push_back(mk(0, 2'b00, RAM+32'h20, 0, 2'b01, 32'h88880007, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'h88880007, 0, 2'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b11, 32'hAAAA0000, 32'hBBBB0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'd0));

    // Reset block
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      set_in(v.rst, v.req, v.a0, v.a1, v.drv, v.rd0, v.rd1, v.derr);
      check($sformatf("v%0d_gnt", i), 32'(host_gnt_o), 32'(v.gnt));
      check($sformatf("v%0d_dreq", i), 32'(device_req_o), 32'(v.dreq));
      check($sformatf("v%0d_rvalid", i), 32'(host_rvalid_o), 32'(v.hrv));
      check($sformatf("v%0d_err", i), 32'(host_err_o & host_rvalid_o), 32'(v.herr));
      check($sformatf("v%0d_outst", i), 32'(outstanding_o), 32'(v.outst));
      check($sformatf("v%0d_fault", i), 32'(fault_o), 32'd0);
      if (v.hrv[0]) check($sformatf("v%0d_rdata0", i), host_rdata_o[0], v.hrd0);
      if (v.hrv[1]) check($sformatf("v%0d_rdata1", i), host_rdata_o[1], v.hrd1);
      for (int d = 0; d < 2; d++) begin
        if (v.dreq[d]) begin
          logic h;
          h = v.gnt[1];
          check($sformatf("v%0d_daddr%0d", i, d), device_addr_o[d], h ? v.a1 : v.a0);
          check($sformatf("v%0d_dwe%0d", i, d), 32'(device_we_o[d]), h ? 32'd1 : 32'd0);
          check($sformatf("v%0d_dbe%0d", i, d), 32'(device_be_o[d]), h ? 32'h3 : 32'hF);
          check($sformatf("v%0d_dwdata%0d", i, d), device_wdata_o[d],
                h ? 32'h1B1B_1B1B : 32'h0A0A_0A0A);
        end
      end
    end

    // Timeout: device 0 never answers; host 1's entry behind it still drains.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h9999_0008);
    set_in(0, 2'b01, RAM, DV1, 0, 0, 0, 0);
    check("to_gnt0", 32'(host_gnt_o), 32'h1);
    set_in(0, 2'b10, RAM, DV1, 0, 0, 0, 0);
    check("to_gnt1", 32'(host_gnt_o), 32'h2);
    resp_cycle = -1;
    for (int k = 2; k <= 40; k++) begin
      set_in(0, 2'b00, RAM, DV1, 0, 32'h5555_5555, 0, 0);
      if (host_rvalid_o != 2'b00) begin
        resp_cycle = k;
        break;
      end
    end
    if (resp_cycle < 0) begin
      check("to_wait_expired", 32'd1, 32'd0);
    end else begin
      check("to_latency", resp_cycle, 32'd16);
      check("to_rvalid", 32'(host_rvalid_o), 32'h1);
      check("to_err", 32'(host_err_o[0]), 32'h1);
      sb_check("to_rdata0", host_rdata_o[0]);
    end
    set_in(0, 2'b11, RAM, DV1, 2'b10, 0, 32'h9999_0008, 0);
    check("to_fault_set", 32'(fault_o), 32'h1);
    check("to_gnt_blocked_a", 32'(host_gnt_o), 32'h0);
    check("to_drain_rvalid", 32'(host_rvalid_o), 32'h2);
    check("to_drain_err", 32'(host_err_o[1]), 32'h0);
    sb_check("to_drain_rdata1", host_rdata_o[1]);
    set_in(0, 2'b11, RAM, DV1, 0, 0, 0, 0);
    check("to_gnt_blocked_b", 32'(host_gnt_o), 32'h0);
    check("to_outst_drained", 32'(outstanding_o), 32'h0);
    check("to_fault_sticky", 32'(fault_o), 32'h1);
    check("to_sb_empty", exp_q.size(), 32'd0);

    // RST clears fault; then reset with two outstanding flushes the tracker.
    set_in(1, 2'b00, RAM, DV1, 0, 0, 0, 0);
    set_in(0, 2'b01, RAM, DV1, 0, 0, 0, 0);
    check("rst_fault_clear", 32'(fault_o), 32'h0);
    check("rst_outst_clear", 32'(outstanding_o), 32'h0);
    check("rst_gnt_resume", 32'(host_gnt_o), 32'h1);
    set_in(0, 2'b10, RAM, DV1, 0, 0, 0, 0);
    check("fl_gnt1", 32'(host_gnt_o), 32'h2);
    check("fl_outst1", 32'(outstanding_o), 32'h1);
    set_in(0, 2'b00, RAM, DV1, 0, 0, 0, 0);
    check("fl_outst2", 32'(outstanding_o), 32'h2);
    set_in(1, 2'b00, RAM, DV1, 2'b11, 32'h1, 32'h2, 0);
    check("fl_rvalid_in_rst", 32'(host_rvalid_o), 32'h0);
    set_in(0, 2'b00, RAM, DV1, 2'b11, 32'h1, 32'h2, 0);
    check("fl_stale_rvalid", 32'(host_rvalid_o), 32'h0);
    check("fl_outst_zero", 32'(outstanding_o), 32'h0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_xbar.md
Name: bus_rr_xbar

Overview:
- Parametrised successor to the single-level shared bus: N hosts, M devices, address-decoded.
- Adds round-robin arbitration, up to MaxOutstanding pipelined in-order transactions, and a local error response for decode misses.
- Adds a response-timeout watchdog that faults and locks the bus.
- Sits between the core data port, the debug SBA host and all memory-mapped peripherals (RAM, GPIO, UART, timer, SPI, sim ctrl, debug mem).

Parameters:
- NrHosts, 2, number of bus hosts (1..8)
- NrDevices, 8, number of address-mapped devices (1..16)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width
- MaxOutstanding, 2, in-order tracker depth (1..8)
- TimeoutCycles, 1024, cycles the head transaction may wait for device rvalid before fault

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- host_req_i  in  1 x NrHosts  host request
- host_gnt_o  out  1 x NrHosts  grant, same cycle as accepted request
- host_addr_i  in  AddressWidth x NrHosts  byte address
- host_we_i  in  1 x NrHosts  write enable
- host_be_i  in  DataWidth/8 x NrHosts  byte enables
- host_wdata_i  in  DataWidth x NrHosts  write data
- host_rvalid_o  out  1 x NrHosts  response valid
- host_rdata_o  out  DataWidth x NrHosts  read data
- host_err_o  out  1 x NrHosts  response error, qualified by rvalid
- device_req_o  out  1 x NrDevices  device request
- device_addr_o / device_we_o / device_be_o / device_wdata_o  out  per device  forwarded from the granted host
- device_rvalid_i  in  1 x NrDevices  device response valid
- device_rdata_i  in  DataWidth x NrDevices  device read data
- device_err_i  in  1 x NrDevices  device error
- cfg_device_addr_base_i  in  AddressWidth x NrDevices  decode base
- cfg_device_addr_mask_i  in  AddressWidth x NrDevices  decode mask
- fault_o  out  1  sticky timeout fault
- outstanding_o  out  $clog2(MaxOutstanding+1)  tracker occupancy

Behaviour:
- Reset: all outputs 0. Tracker empty. Timeout counter 0. fault_o=0. RR last-grant pointer = NrHosts-1, so host 0 has highest priority.
- Arbitration (combinational): eligible = host_req_i while tracker count < MaxOutstanding and fault_o=0.
  - Full blocks grants even if a pop occurs in the same cycle.
  - Winner = first eligible host scanning from last_grant+1 with wrap. Pointer updates to the winner on grant only.
  - At most one grant per cycle.
- Decode: hit[d] = (addr & mask[d]) == base[d]. Lowest hit index wins.
  - On grant with hit: device_req_o[d]=1 in the same cycle, with addr/we/be/wdata of the winner. All other device_req_o=0.
  - Decode miss: no device_req; the entry is flagged miss.
- Tracker: FIFO of {host_idx, dev_idx, miss}. Push on grant.
- Response: evaluated on the head entry only; responses are strictly in order.
  - Non-miss head: when device_rvalid_i[head.dev]=1, host_rvalid_o[head.host]=1 in the same cycle, with rdata/err from that device. Pop.
  - Miss head: respond with err=1 and rdata=0 in the cycle it is head, never the grant cycle (minimum latency 1). Pop.
  - device_rvalid_i from a non-head device, or with the tracker empty, is ignored.
- Simultaneous push and pop: allowed when count < MaxOutstanding; occupancy unchanged.
- Timeout: counter increments each cycle the head is non-miss and unanswered. It clears on pop or when the tracker is empty.
  - When counter == TimeoutCycles-1 with no rvalid: respond err=1, rdata=0 to head.host and pop.
  - Set fault_o=1. fault_o blocks all further grants; remaining entries still drain normally.
  - Only RST clears fault_o.
- Reset mid-operation: tracker flushed. Late device rvalids after reset are ignored.
- Widths: be width = DataWidth/8. Index widths = max(1, $clog2(N)).

Decomposition:
- Package bus_xbar_pkg holds:
  - HostIdxW and DevIdxW helper functions
  - the tracker entry struct {host_idx, dev_idx, miss}
  - the localparam error rdata value (0)
- Sub-module bus_rr_arbiter: parametrised NrHosts, req vector in, one-hot gnt plus index out, last-grant pointer register with enable.
- Tracker FIFO, decode and timeout stay in bus_rr_xbar.

Test Plan:
- Single host, RAM at 0x00100000 mask 0xFFFF0000: read 0x00100010. Device rvalid one cycle later with 0xCAFEF00D. Host sees gnt same cycle; rvalid+rdata one cycle later; err=0.
- Hosts 0 and 1 both request continuously, MaxOutstanding=2, device answers every cycle:
  - grants alternate 0,1,0,1 starting with host 0
  - responses route back to the correct host in order.
- Address 0x40000000 (no match): gnt same cycle, no device_req, err=1, rdata=0 next cycle.
  - Miss queued behind a pending RAM read responds only after the RAM response.
- MaxOutstanding=2, device withholds rvalid: third request not granted; outstanding_o=2.
  - Release rvalid: grant resumes the cycle after occupancy drops.
- TimeoutCycles=16, device never responds:
  - err response exactly 16 cycles after the entry reaches head
  - fault_o=1; later host_req never granted
  - RST pulse clears fault_o and occupancy.
- Assert RST with 2 outstanding, then drive a stale device rvalid: no host_rvalid; outstanding_o=0.
